pc_sel_unit: RTL and testbench

//  Parametrised next-PC generator with an integrated PC register; successor to the combinational next-PC mux.

---
 rtl/pc_sel_unit.sv | 133 +++++++++++++
 tb/tb_pc_sel_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_sel_unit.sv
// rtl/pc_sel_unit.sv - next-PC select with PC register, stall hold and redirect buffering
//
// Purpose: IF-stage PC register plus next-PC selection among exception vector,
//   ID-stage branch target, jump target, register jump and sequential PC.
//   A redirect that arrives during a stall is buffered and applied when the stall drops.
//   The optional redirect counter is built only when PC_SEL_PERF_EN is defined.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   stall                 hold PC (exceptions still load)
//   beq_taken, bne_taken  branch taken in ID, target br_target
//   jump, j_target        j/jal in ID
//   jr, jr_target         register jump in ID
//   exc                   exception request, loads EXC_VECTOR
//   pc                    current PC (registered)
//   pc_plus4              pc + PC_STEP (combinational)
//   redirect              1-cycle pulse after a non-sequential load (flush IF/ID)
//   misalign              1-cycle pulse when the loaded target had addr[1:0] != 0
//   pending               a redirect is buffered waiting for the stall to drop
//   redirect_cnt          saturating count of non-sequential loads (PC_SEL_PERF_EN)

module pc_sel_unit #(
  parameter int              XLEN         = 32,
  parameter int              PC_STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'('h80)
`ifdef PC_SEL_PERF_EN
  ,
  parameter int              CNT_W        = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            beq_taken,
  input  logic            bne_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jump,
  input  logic [XLEN-1:0] j_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  input  logic            exc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            misalign,
  output logic            pending
`ifdef PC_SEL_PERF_EN
  ,
  output logic [CNT_W-1:0] redirect_cnt
`endif
);

  logic            cand_valid;
  logic [XLEN-1:0] cand_target;
  logic            load_valid;
  logic [XLEN-1:0] load_target;
  logic [XLEN-1:0] buf_target;

  assign pc_plus4 = pc + XLEN'(PC_STEP);

  // ID-stage redirect candidate, highest priority first
  always_comb begin
    cand_valid  = 1'b1;
    cand_target = pc;
    if (beq_taken || bne_taken) begin
      cand_target = br_target;
    end else if (jump) begin
      cand_target = j_target;
    end else if (jr) begin
      cand_target = jr_target;
    end else begin
      cand_valid = 1'b0;
    end
  end

  // Non-sequential load this edge. A buffered target is older than any
  // candidate presented in the same cycle, so it wins and the new one drops.
  always_comb begin
    load_valid  = 1'b0;
    load_target = pc;
    if (exc) begin
      load_valid  = 1'b1;
      load_target = EXC_VECTOR;
    end else if (!stall) begin
      if (pending) begin
        load_valid  = 1'b1;
        load_target = buf_target;
      end else if (cand_valid) begin
        load_valid  = 1'b1;
        load_target = cand_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      redirect   <= 1'b0;
      misalign   <= 1'b0;
      pending    <= 1'b0;
      buf_target <= '0;
    end else begin
      redirect <= load_valid;
      misalign <= load_valid && (load_target[1:0] != 2'b00);

      if (load_valid) begin
        pc <= {load_target[XLEN-1:2], 2'b00};
      end else if (!stall) begin
        pc <= pc_plus4;
      end

      // Buffer is consumed on any unstalled cycle and flushed by an exception;
      // during a stall only the first redirect is captured.
      if (exc || !stall) begin
        pending <= 1'b0;
      end else if (!pending && cand_valid) begin
        pending    <= 1'b1;
        buf_target <= cand_target;
      end
    end
  end

`ifdef PC_SEL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt <= '0;
    end else if (load_valid && (redirect_cnt != {CNT_W{1'b1}})) begin
      redirect_cnt <= redirect_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sel_unit.sv
// tb/tb_pc_sel_unit.sv - scoreboard bench for pc_sel_unit
module tb_pc_sel_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        beq_taken = 1'b0;
  logic        bne_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump = 1'b0;
  logic [31:0] j_target = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        exc = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misalign;
  logic        pending;
`ifdef PC_SEL_PERF_EN
  logic [1:0]  redirect_cnt;
`endif

`ifdef PC_SEL_PERF_EN
  pc_sel_unit #(.CNT_W(2)) dut (
`else
  pc_sel_unit dut (
`endif
    .clk(clk), .reset(reset), .stall(stall),
    .beq_taken(beq_taken), .bne_taken(bne_taken), .br_target(br_target),
    .jump(jump), .j_target(j_target), .jr(jr), .jr_target(jr_target),
    .exc(exc), .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
    .misalign(misalign), .pending(pending)
`ifdef PC_SEL_PERF_EN
    , .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic [31:0] p4;
    logic        red;
    logic        mis;
    logic        pend;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [1:0] model_cnt = 2'd0;

  task automatic check(input int tag, input string what, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", tag, what, act, req);
    end
  endtask

  // Monitor: the DUT presents a new state every edge; compare just after it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, "pc", pc, e.pc);
      check(e.tag, "pc_plus4", pc_plus4, e.p4);
      check(e.tag, "redirect", 32'(redirect), 32'(e.red));
      check(e.tag, "misalign", 32'(misalign), 32'(e.mis));
      check(e.tag, "pending", 32'(pending), 32'(e.pend));
`ifdef PC_SEL_PERF_EN
      check(e.tag, "redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
`endif
    end
  end

  int step_no = 0;

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic rst, input logic stl,
                      input logic beq, input logic bne, input logic [31:0] brt,
                      input logic jmp, input logic [31:0] jt,
                      input logic jrr, input logic [31:0] jrt, input logic ex,
                      input logic [31:0] x_pc, input logic x_red, input logic x_mis,
                      input logic x_pend);
    exp_t x;
    @(negedge clk);
    reset = rst; stall = stl; beq_taken = beq; bne_taken = bne; br_target = brt;
    jump = jmp; j_target = jt; jr = jrr; jr_target = jrt; exc = ex;
    if (rst) model_cnt = 2'd0;
    else if (x_red && model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
    step_no++;
    x.tag = step_no; x.pc = x_pc; x.p4 = x_pc + 32'd4;
    x.red = x_red; x.mis = x_mis; x.pend = x_pend; x.cnt = model_cnt;
    sb.push_back(x);
  endtask

  initial begin
    // reset and free-running sequential fetch
    step(1,0, 0,0,0, 0,0, 0,0, 0, 32'h0,     0,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h4,     0,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h8,     0,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'hC,     0,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h10,    0,0,0);
    // branch beats jump
    step(0,0, 1,0,32'h40, 1,32'h80, 0,0, 0, 32'h40, 1,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h44,    0,0,0);
    // redirect during stall is buffered, first wins, older beats new
    step(0,1, 0,0,0, 1,32'h200, 0,0, 0, 32'h44, 0,0,1);
    step(0,1, 0,0,0, 0,0, 0,0, 0, 32'h44,    0,0,1);
    step(0,1, 0,0,0, 1,32'h300, 0,0, 0, 32'h44, 0,0,1);
    step(0,0, 0,0,0, 0,0, 1,32'h500, 0, 32'h200, 1,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h204,   0,0,0);
    // exception overrides stall and discards the buffer
    step(0,1, 0,0,0, 1,32'h600, 0,0, 0, 32'h204, 0,0,1);
    step(0,1, 0,0,0, 0,0, 0,0, 1, 32'h80,    1,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h84,    0,0,0);
    // misaligned jr target, then wrap of pc_plus4
    step(0,0, 0,0,0, 0,0, 1,32'h1002, 0, 32'h1000, 1,1,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h1004,  0,0,0);
    step(0,0, 0,0,0, 0,0, 1,32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h0,     0,0,0);
    // bne path with misaligned target; jump beats jr
    step(0,0, 0,1,32'h41, 0,0, 0,0, 0, 32'h40, 1,1,0);
    step(0,0, 0,0,0, 1,32'h900, 1,32'hA00, 0, 32'h900, 1,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h904,   0,0,0);
    // reset mid-stall discards the buffered redirect
    step(0,1, 0,0,0, 1,32'h700, 0,0, 0, 32'h904, 0,0,1);
    step(1,1, 0,0,0, 0,0, 0,0, 0, 32'h0,     0,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h4,     0,0,0);
    // back-to-back redirects exercise counter saturation
    step(0,0, 0,0,0, 1,32'h100, 0,0, 0, 32'h100, 1,0,0);
    step(0,0, 0,0,0, 1,32'h200, 0,0, 0, 32'h200, 1,0,0);
    step(0,0, 0,0,0, 1,32'h300, 0,0, 0, 32'h300, 1,0,0);
    step(0,0, 0,0,0, 1,32'h400, 0,0, 0, 32'h400, 1,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 1, 32'h80,    1,0,0);
    step(1,0, 0,0,0, 0,0, 0,0, 0, 32'h0,     0,0,0);
    step(0,0, 0,0,0, 0,0, 0,0, 0, 32'h4,     0,0,0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
